pwl_table_loader: RTL and testbench
===================================

// Module: pwl_table_loader
// PURPOSE
//  Runtime writer for the PWL coefficient tables read by the PWL evaluator.
//  Accepts a valid/ready word stream and assembles {offset, slope} entries.
//  Writes each entry to the table RAM write port at {setting, segment index}.
//  Checks a trailing modular checksum and flags load errors.
// PARAMETERS
//  setting_width  1   width of setting select; table bank = setting
//  addr_width     4   segment index width; 2**addr_width entries per bank
//  offset_width   18  signed offset field width (entry MSBs)
//  slope_width    18  signed slope field width (entry LSBs)
//  bus_width      16  stream word width
// PORTS
//  clk        in   1                          system clock, rising edge
//  rst        in   1                          async, active-high reset
//  start      in   1                          pulse: begin loading bank start_setting
//  start_setting in setting_width             bank to load, sampled with start
//  abort      in   1                          sync abort of an in-progress load
//  in_data    in   bus_width                  stream word
//  in_valid   in   1                          in_data valid
//  in_ready   out  1                          loader accepts word this cycle
//  wr_en      out  1                          table write strobe, one cycle
//  wr_addr    out  setting_width+addr_width   {setting, index}
//  wr_data    out  offset_width+slope_width   {offset, slope}, same packing the evaluator reads
//  busy       out  1                          load in progress
//  done       out  1                          one-cycle pulse at end of load
//  err        out  1                          checksum mismatch or abort; sticky until next start
// BEHAVIOUR
//  - ENTRY_W = offset_width+slope_width; BEATS = ceil(ENTRY_W/bus_width) (3 at defaults).
//  - Reset (async assert): state=IDLE; in_ready, wr_en, busy, done, err = 0; wr_addr, wr_data = 0.
//  - Handshake: a word transfers on a rising edge with in_valid & in_ready.
//    in_valid may drop at any time; no word is dropped or duplicated.
//  - FSM states IDLE, LOAD, CHECK:
//    IDLE: in_ready=0, busy=0. start=1: latch start_setting; clear idx, beat and sum; clear err; go to LOAD.
//    LOAD: in_ready=1, busy=1. Each transfer:
//      - place in_data at bits [beat*bus_width +: bus_width] of the assembly register (LSB-first);
//      - sum <= sum + in_data, modulo 2**bus_width;
//      - beat++.
//      On the transfer with beat==BEATS-1, in the next cycle:
//      - wr_en=1 for one cycle; wr_addr={setting, idx};
//      - wr_data = assembly[ENTRY_W-1:0]; pad bits above ENTRY_W are ignored but included in sum;
//      - idx++ and beat resets to 0.
//      Transfer completing entry idx==2**addr_width-1: go to CHECK.
//    CHECK: in_ready=1, busy=1. One transfer: err <= (in_data != sum); go to IDLE.
//      done=1 in the following cycle, together with busy=0.
//  - Latency: final beat handshake -> wr_en: 1 cycle. Checksum handshake -> done: 1 cycle.
//  - Throughput: one word per cycle sustained; wr_en never asserts on consecutive cycles when BEATS>1.
//  - start while busy is ignored. start and abort in the same IDLE cycle: abort wins, remain IDLE.
//  - abort in LOAD/CHECK: next cycle IDLE, busy=0, err=1, no done.
//    A completed entry's pending wr_en still issues; a partial entry is discarded.
//  - Async reset mid-load: outputs cleared immediately. Entries already written stay in RAM.
//  - idx wraps only via the state exit; there are never more than 2**addr_width writes per load.
//  - The loaded bank must not be selected by the evaluator during the load; the loader does not interlock.
// TESTING
//  1. Reset: assert rst mid-cycle -> all outputs 0 asynchronously; no wr_en after release.
//  2. Defaults, start_setting=1, entry i = {offset=i, slope=-i}, correct checksum, in_valid held high:
//     -> 16 wr_en pulses; wr_addr 0x10..0x1F; wr_data={18'di, -18'sdi}; done 1 cycle; err=0; 49 in_ready cycles.
//  3. Same stream with checksum+1 -> all 16 writes occur; done=1; err=1 (held until next start).
//  4. in_valid toggled 1,0,1,0 through the load -> identical write sequence to test 2; no drop or duplication.
//  5. start pulsed while busy -> ignored. abort after 5 entries plus 1 beat:
//     -> exactly 5 writes; busy=0 next cycle; err=1; done never asserts.
//  6. rst asserted mid-load, then start_setting=0 with a full clean load -> 16 writes to 0x00..0x0F; err=0.

Source files
------------

// File: rtl/pwl_table_loader_if.sv
// Stream and table-write signals shared by the PWL table loader and its producer/RAM side.
// The slave modport is the loader view. The master modport is the stream source and RAM sink.
interface pwl_table_loader_if #(
    parameter int bus_width  = 16,
    parameter int waddr_width = 5,
    parameter int wdata_width = 36
);
    logic [bus_width-1:0]   in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wr_en;
    logic [waddr_width-1:0] wr_addr;
    logic [wdata_width-1:0] wr_data;

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pwl_table_loader.sv
// Streams {offset, slope} PWL entries into one table bank, LSB-first words per entry,
// and finishes each load by checking a trailing modulo-2**bus_width checksum.
module pwl_table_loader #(
    parameter int setting_width = 1,
    parameter int addr_width    = 4,
    parameter int offset_width  = 18,
    parameter int slope_width   = 18,
    parameter int bus_width     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [setting_width-1:0] start_setting,
    input  logic                     abort,
    pwl_table_loader_if.slave        bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int ENTRY_W = offset_width + slope_width;
    localparam int BEATS   = (ENTRY_W + bus_width - 1) / bus_width;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ASM_W   = BEATS * bus_width;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

    state_t                   state_q, state_d;
    logic [setting_width-1:0] setting_q;
    logic [addr_width-1:0]    idx_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [bus_width-1:0]     sum_q;
    logic [ASM_W-1:0]         asm_q, asm_next;
    logic                     fire, last_beat, last_idx;

    // Abort withholds ready so a word offered in the abort cycle is never consumed.
    assign busy        = (state_q != IDLE);
    assign bus.in_ready = busy && !abort;
    assign fire        = bus.in_valid && bus.in_ready;
    assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
    assign last_idx    = (idx_q == {addr_width{1'b1}});

    always_comb begin
        asm_next = asm_q;
        asm_next[beat_q*bus_width +: bus_width] = bus.in_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start && !abort) state_d = LOAD;
            LOAD: begin
                if (abort)                              state_d = IDLE;
                else if (fire && last_beat && last_idx) state_d = CHECK;
            end
            CHECK: if (abort || fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath: entry assembly, running checksum and the registered RAM write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setting_q   <= '0;
            idx_q       <= '0;
            beat_q      <= '0;
            sum_q       <= '0;
            asm_q       <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        setting_q <= start_setting;
                        idx_q     <= '0;
                        beat_q    <= '0;
                        sum_q     <= '0;
                        err       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        err <= 1'b1;
                    end else if (fire) begin
                        asm_q <= asm_next;
                        sum_q <= sum_q + bus.in_data;
                        if (last_beat) begin
                            beat_q      <= '0;
                            idx_q       <= idx_q + 1'b1;
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= {setting_q, idx_q};
                            bus.wr_data <= ENTRY_W'(asm_next);
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        err <= 1'b1;
                    end else if (fire) begin
                        err  <= (bus.in_data != sum_q);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pwl_table_loader.sv
// Directed bench for pwl_table_loader: full loads, bad checksum, stalls, abort and async reset.
module tb_pwl_table_loader;
    localparam int SW = 1, AW = 4, OW = 18, SLW = 18, BW = 16;
    localparam int ENTRY_W = OW + SLW;
    localparam int NWORDS  = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [SW-1:0] start_setting = '0;
    logic abort = 1'b0;
    logic busy, done, err;

    pwl_table_loader_if #(.bus_width(BW), .waddr_width(SW+AW), .wdata_width(ENTRY_W)) bus ();

    pwl_table_loader #(
        .setting_width(SW), .addr_width(AW), .offset_width(OW),
        .slope_width(SLW), .bus_width(BW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_setting(start_setting),
        .abort(abort), .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int ready_cnt = 0;
    logic prev_wr = 1'b0;
    logic [SW+AW+ENTRY_W-1:0] wr_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Observe registered outputs a little after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.in_ready) ready_cnt++;
        if (bus.wr_en) begin
            checkOutput("wr_en_back_to_back", 64'(prev_wr), 64'd0);
            wr_q.push_back({bus.wr_addr, bus.wr_data});
        end
        if (done) begin
            done_cnt++;
            checkOutput("busy_with_done", 64'(busy), 64'd0);
        end
        prev_wr = bus.wr_en;
    end

    function automatic logic [ENTRY_W-1:0] entry_of(input int e);
        logic [OW-1:0]  off;
        logic [SLW-1:0] slp;
        off = OW'(e);
        slp = SLW'(-e);
        return {off, slp};
    endfunction

    function automatic logic [BW-1:0] stream_word(input int n);
        logic [3*BW-1:0] ext;
        ext = {{(3*BW-ENTRY_W){1'b0}}, entry_of(n / 3)};
        return ext[(n % 3)*BW +: BW];
    endfunction

    function automatic logic [BW-1:0] checksum();
        logic [BW-1:0] s = '0;
        for (int n = 0; n < NWORDS; n++) s = s + stream_word(n);
        return s;
    endfunction

    // Called just after a falling edge; returns just after the falling edge following the transfer.
    task automatic send_word(input logic [BW-1:0] w);
        int n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) checkOutput("handshake_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic start_load(input logic [SW-1:0] s);
        start_setting = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int nwords, input bit toggle, input int csum_delta);
        for (int n = 0; n < nwords; n++) begin
            send_word(stream_word(n));
            if (toggle) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        if (nwords == NWORDS) send_word(checksum() + BW'(csum_delta));
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input logic [SW-1:0] s, input int expect_n);
        checkOutput({tag, "_write_count"}, 64'(wr_q.size()), 64'(expect_n));
        for (int i = 0; i < expect_n && i < wr_q.size(); i++)
            checkOutput($sformatf("%s_write_%0d", tag, i), 64'(wr_q[i]), 64'({s, AW'(i), entry_of(i)}));
    endtask

    task automatic clear_counts();
        wr_q.delete();
        done_cnt  = 0;
        ready_cnt = 0;
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        #3;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("reset_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_wr_addr", 64'(bus.wr_addr), 64'd0);
        checkOutput("reset_wr_data", 64'(bus.wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean load of bank 1 with in_valid held high.
        clear_counts();
        start_load(1'b1);
        applyStimulus(NWORDS, 1'b0, 0);
        check_writes("clean", 1'b1, 16);
        checkOutput("clean_done_count", 64'(done_cnt), 64'd1);
        checkOutput("clean_err", 64'(err), 64'd0);
        checkOutput("clean_ready_cycles", 64'(ready_cnt), 64'd49);
        checkOutput("clean_busy_after", 64'(busy), 64'd0);

        // Wrong checksum: every entry still written, err raised and held.
        clear_counts();
        start_load(1'b1);
        applyStimulus(NWORDS, 1'b0, 1);
        check_writes("badsum", 1'b1, 16);
        checkOutput("badsum_done_count", 64'(done_cnt), 64'd1);
        checkOutput("badsum_err", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("badsum_err_sticky", 64'(err), 64'd1);

        // Stalled stream; the new start also clears the sticky err.
        clear_counts();
        start_load(1'b1);
        #1 checkOutput("start_clears_err", 64'(err), 64'd0);
        @(negedge clk);
        applyStimulus(NWORDS, 1'b1, 0);
        check_writes("toggle", 1'b1, 16);
        checkOutput("toggle_done_count", 64'(done_cnt), 64'd1);
        checkOutput("toggle_err", 64'(err), 64'd0);

        // start together with abort in IDLE stays idle.
        start_setting = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1 checkOutput("start_abort_idle_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // Ignored start mid-load, then abort after 5 entries plus one beat.
        clear_counts();
        start_load(1'b1);
        for (int n = 0; n < 16; n++) begin
            if (n == 7) begin
                start_setting = 1'b0;
                start = 1'b1;
            end
            send_word(stream_word(n));
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_err", 64'(err), 64'd1);
        repeat (8) @(negedge clk);
        check_writes("abort", 1'b1, 5);
        checkOutput("abort_done_count", 64'(done_cnt), 64'd0);

        // Asynchronous reset mid-load, then a clean load of bank 0.
        clear_counts();
        start_load(1'b1);
        for (int n = 0; n < 20; n++) send_word(stream_word(n));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("midrst_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("midrst_wr_addr", 64'(bus.wr_addr), 64'd0);
        checkOutput("midrst_wr_data", 64'(bus.wr_data), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        repeat (4) @(negedge clk);
        checkOutput("midrst_no_writes_after", 64'(wr_q.size()), 64'd0);

        clear_counts();
        start_load(1'b0);
        applyStimulus(NWORDS, 1'b0, 0);
        check_writes("bank0", 1'b0, 16);
        checkOutput("bank0_done_count", 64'(done_cnt), 64'd1);
        checkOutput("bank0_err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
